// File: rtl/load_store_unit_if.sv
// Purpose: data-memory port between the load/store unit and data memory (req/gnt/rvalid).
// Latency: none; this is a wiring bundle only.
// Backpressure: a request holds until dmem_gnt; read data is accepted only on dmem_rvalid.
// Ports: dmem_req/we/addr/be/wdata are driven by the master; dmem_gnt/rvalid/rdata by the slave.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: RISC-V data-memory access stage; checks legality, drives lanes, extends load data.
// Latency: store 2 cycles, load 3 cycles minimum; each gnt or rvalid wait cycle adds one.
// Backpressure: busy stays high from issue until done; start is ignored while busy.
// Ports: clk/rst_n; start + decoder bundle (mem_read, mem_write, write_enable, read_enable),
//   addr, wdata in; busy, done, err, rdata out; dmem master modport to data memory.
module load_store_unit (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [3:0]                 write_enable,
  input  logic [4:0]                 read_enable,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [31:0]                rdata,
  load_store_unit_if.master          dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  // Everything about the access still needed after issue.
  typedef struct packed {
    logic       is_load;
    logic [4:0] ld_type;
    logic [1:0] lo;
  } op_t;

  state_t      state;
  op_t         op_q;

  logic        is_load;
  logic        is_store;
  logic        re_onehot;
  logic        we_legal;
  logic [3:0]  size_mask;
  logic        misalign;
  logic        legal;
  logic [3:0]  lane_be;
  logic [31:0] store_data;
  logic [31:0] shifted;
  logic [31:0] load_result;

  // Issue-side decode; only consulted in IDLE when start is high.
  always_comb begin
    is_load   = mem_read & ~mem_write;
    is_store  = mem_write & ~mem_read;
    re_onehot = (read_enable != 5'd0) && ((read_enable & (read_enable - 5'd1)) == 5'd0);
    we_legal  = (write_enable == 4'b0001) || (write_enable == 4'b0011) ||
                (write_enable == 4'b1111);

    size_mask = write_enable;
    if (is_load) begin
      if (read_enable[2])                         size_mask = 4'b1111;
      else if (read_enable[1] || read_enable[4])  size_mask = 4'b0011;
      else                                        size_mask = 4'b0001;
    end

    misalign = ((size_mask == 4'b0011) && addr[0]) ||
               ((size_mask == 4'b1111) && (addr[1:0] != 2'b00));
    legal    = ((is_load && re_onehot) || (is_store && we_legal)) && !misalign;
    lane_be  = size_mask << addr[1:0];

    case (size_mask)
      4'b0001: store_data = {4{wdata[7:0]}};
      4'b0011: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by load type.
  always_comb begin
    shifted = dmem.dmem_rdata >> {op_q.lo, 3'b000};
    if (op_q.ld_type[0])      load_result = {{24{shifted[7]}}, shifted[7:0]};
    else if (op_q.ld_type[1]) load_result = {{16{shifted[15]}}, shifted[15:0]};
    else if (op_q.ld_type[3]) load_result = {24'd0, shifted[7:0]};
    else if (op_q.ld_type[4]) load_result = {16'd0, shifted[15:0]};
    else                      load_result = shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      rdata           <= 32'd0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'd0;
      dmem.dmem_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              op_q.is_load    <= is_load;
              op_q.ld_type    <= is_load ? read_enable : 5'd0;
              op_q.lo         <= addr[1:0];
              state           <= REQ;
              busy            <= 1'b1;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= is_store;
              dmem.dmem_addr  <= {addr[31:2], 2'b00};
              dmem.dmem_be    <= lane_be;
              dmem.dmem_wdata <= is_store ? store_data : 32'd0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        REQ: begin
          // rvalid is deliberately not looked at here, even alongside gnt.
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            if (op_q.is_load) begin
              state <= WAIT_R;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        WAIT_R: begin
          if (dmem.dmem_rvalid) begin
            rdata <= load_result;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RISC-V core. Sits directly downstream of the control decoder and consumes its memory-control bundle (`mem_read`, `mem_write`, `write_enable`, `read_enable`). It takes one load/store per start pulse and checks alignment and op legality. It then drives a req/gnt/rvalid data-memory port with byte lanes and replicated write data, and returns a sign- or zero-extended load result. `busy` stalls the pipeline while an access is outstanding.

## Interface
Parameters: none (XLEN fixed at 32).

- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle issue pulse; sampled only in IDLE.
- `mem_read`  in  1  — op is a load.
- `mem_write`  in  1  — op is a store.
- `write_enable`  in  4  — store size mask, unshifted: 0001 = SB, 0011 = SH, 1111 = SW.
- `read_enable`  in  5  — one-hot load type: [0] LB, [1] LH, [2] LW, [3] LBU, [4] LHU.
- `addr`  in  32  — byte address.
- `wdata`  in  32  — store data (rs2).
- `busy`  out  1  — high whenever the state is not IDLE.
- `done`  out  1  — one-cycle pulse when the access completes.
- `err`  out  1  — one-cycle pulse when an op is rejected.
- `rdata`  out  32  — extended load result; holds until the next load completes.
- `dmem_req`  out  1  — memory request.
- `dmem_we`  out  1  — 1 = write.
- `dmem_addr`  out  32  — word address, `{addr[31:2], 2'b00}`.
- `dmem_be`  out  4  — byte enables.
- `dmem_wdata`  out  32  — lane-replicated store data.
- `dmem_gnt`  in  1  — request accepted.
- `dmem_rvalid`  in  1  — read data valid.
- `dmem_rdata`  in  32  — read word.

## Operation
- **States:** IDLE, REQ, WAIT_R, DONE.
- **IDLE, start = 0:** no action.
- **IDLE, start = 1, legality check:** an op is illegal if any of the following hold:
  - `mem_read == mem_write`;
  - load with `read_enable` not one-hot;
  - store with `write_enable` not in {0001, 0011, 1111};
  - half access with `addr[0] = 1`;
  - word access with `addr[1:0] != 0`.
- **Illegal op:** `err` pulses next cycle; state stays IDLE; no `dmem_req`.
- **Legal op:** latch `addr`, op, size and `wdata`; go to REQ.
- **REQ:** `dmem_req = 1`.
  - All `dmem_*` outputs are registered and stay stable until `dmem_gnt`.
  - On `dmem_gnt`: a store goes to DONE; a load goes to WAIT_R.
- **WAIT_R:** on `dmem_rvalid`, capture the extracted, extended value into `rdata` and go to DONE.
  - `dmem_rvalid` is ignored in every other state.
- **DONE:** `done = 1` for one cycle, then IDLE.
- **`start` while busy:** ignored, no `err`.
- **Store lanes:** `dmem_be = write_enable << addr[1:0]`.
  - `dmem_wdata`: SB = `{4{wdata[7:0]}}`, SH = `{2{wdata[15:0]}}`, SW = `wdata`.
- **Load lanes:** `dmem_be` is 0001, 0011 or 1111 shifted left by `addr[1:0]`; `dmem_we = 0`.
  - Extract `dmem_rdata >> (8*addr[1:0])`, low byte or halfword.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- **Reset values:** state IDLE; all outputs 0, including `rdata`.
- **Reset mid-access:** the access is abandoned and `dmem_req` drops asynchronously. A late `dmem_rvalid` after reset is ignored.

## Timing
- **Cycle 0:** `start` sampled.
- **Cycle 1:** `dmem_req` high (or `err` pulse if illegal).
- **Store, zero-wait grant (gnt in cycle 1):**
  - `done` in cycle 2;
  - `busy` in cycles 1–2;
  - next `start` accepted in cycle 3.
- **Load, gnt in cycle 1, rvalid in cycle 2:**
  - `done` and new `rdata` in cycle 3 (minimum load latency 3 cycles);
  - `rdata` updates in the same cycle `done` rises.
- **Each gnt wait cycle** adds one cycle; **each rvalid wait cycle** adds one cycle.
- **`rvalid` coincident with `gnt`:** not accepted.
- **`err`:** rises in cycle 1; `busy` never rises.

## Test plan
- **SB:** addr 0x0000_0103, wdata 0x0000_00A5, gnt in cycle 1 → cycle 1: `dmem_addr` 0x100, `dmem_be` 1000, `dmem_wdata` 0xA5A5_A5A5, `dmem_we` 1; `done` in cycle 2.
- **LB and LBU:** addr 0x102, `dmem_rdata` 0x0080_0000 → LB `rdata` 0xFFFF_FF80, LBU `rdata` 0x0000_0080; `dmem_be` 0100; `done` in cycle 3.
- **Illegal ops:** LW at 0x102, SH at 0x001, and `mem_read = mem_write = 1` → `err` pulse in cycle 1; no `dmem_req`; `busy` stays 0; `rdata` unchanged.
- **Delayed handshake:** LHU at 0x002, gnt held low 3 cycles then high, rvalid 2 cycles later with 0xBEEF_1234 → `dmem_*` stable during the wait; `busy` high throughout; `rdata` 0x0000_BEEF; a `start` pulsed mid-access is ignored.
- **Reset mid-access:** `rst_n` low during WAIT_R → `dmem_req`, `busy`, `done` 0 immediately; state IDLE. After release, a late `dmem_rvalid` produces no `done`; a new SW then completes normally.
- **Back-to-back:** SW then LW, each issued on the first non-busy cycle, with zero-wait gnt/rvalid → `done` pulses in cycles 2 and 6; LW returns the stored word.
